conv_win_seq: RTL and testbench

- Hardware sequencer for the conv layer. It replaces the per-window host pokes (load column, trigger, clear) with an autonomous raster scan over one input feature map.
- Drives the image column buffer read, the image/weight circular-register load/rotate strobes, the PE array clear/ready/phase controls, and a result handshake toward the output packer/host.
- Sits between the host register interface (start/abort/status) and the conv datapath.

---
 rtl/npu_pkg.sv | 28 ++
 rtl/pos_cnt2d.sv | 50 +++++
 rtl/conv_win_seq.sv | 179 +++++++++++++++++
 tb/tb_conv_win_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU conv-layer control blocks.
package npu_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_PRIME, S_CLR, S_CAL, S_MINUS, S_RES, S_SLIDE, S_DONE
  } conv_seq_state_e;

  // PE phase select: positive-image (CAL) vs negative-image (MINUS) pass
  localparam logic PH_CAL   = 1'b0;
  localparam logic PH_MINUS = 1'b1;

  typedef struct packed {
    logic rd_en;
    logic img_rot;
    logic w_shift;
    logic pe_clr;
    logic pe_ready;
    logic pe_neg;
    logic res_valid;
    logic busy;
    logic done;
  } conv_strb_t;

  function automatic int out_dim(input int in_d, input int k_d);
    return in_d - k_d + 1;
  endfunction

endpackage

// File: rtl/pos_cnt2d.sv
// Row/column raster position counter; column is the inner (fast) index.
module pos_cnt2d #(
  parameter int H  = 14,
  parameter int W  = 13,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic [RW-1:0] row_nxt,
  output logic [RW-1:0] col_nxt,
  output logic          col_last,
  output logic          row_last,
  output logic          last
);

  assign col_last = (col == RW'(W-1));
  assign row_last = (row == RW'(H-1));
  assign last     = col_last & row_last;

  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (clr) begin
      row_nxt = '0;
      col_nxt = '0;
    end else if (inc) begin
      if (col_last) begin
        col_nxt = '0;
        row_nxt = row_last ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_nxt;
      col <= col_nxt;
    end
  end

endmodule

// File: rtl/conv_win_seq.sv
// Autonomous raster-scan window sequencer for the conv layer datapath.
module conv_win_seq
  import npu_pkg::*;
#(
  parameter int K_H  = 3,
  parameter int K_W  = 3,
  parameter int IN_H = 16,
  parameter int IN_W = 15,
  parameter int RW   = 5
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          start,
  input  logic          abort,
  output logic          rd_en,
  output logic [RW-1:0] rd_row,
  output logic [RW-1:0] rd_col,
  output logic          col_load,
  output logic          img_rot,
  output logic          w_shift,
  output logic          pe_clr,
  output logic          pe_ready,
  output logic          pe_neg,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_row,
  output logic [RW-1:0] res_col,
  output logic          busy,
  output logic          done
);

  localparam int OUT_H = out_dim(IN_H, K_H);
  localparam int OUT_W = out_dim(IN_W, K_W);
  localparam int KB    = $clog2(K_W + 1);

  conv_seq_state_e st_q, st_d;
  logic [KB-1:0]   k_q, k_d;
  logic            pos_clr, pos_inc;
  logic [RW-1:0]   r_q, c_q, r_d, c_d;
  logic            col_last, row_last, last;

  conv_strb_t    so_d, so_q;
  logic [RW-1:0] rd_row_d, rd_col_d, res_row_d, res_col_d;

  pos_cnt2d #(.H(OUT_H), .W(OUT_W), .RW(RW)) u_pos (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .clr      (pos_clr),
    .inc      (pos_inc),
    .row      (r_q),
    .col      (c_q),
    .row_nxt  (r_d),
    .col_nxt  (c_d),
    .col_last (col_last),
    .row_last (row_last),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= S_IDLE;
      k_q  <= '0;
    end else begin
      st_q <= st_d;
      k_q  <= k_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    k_d     = k_q;
    pos_clr = 1'b0;
    pos_inc = 1'b0;
    unique case (st_q)
      S_IDLE:  if (start) begin
                 st_d    = S_PRIME;
                 k_d     = '0;
                 pos_clr = 1'b1;
               end
      S_PRIME: if (k_q == KB'(K_W-1)) begin
                 k_d  = '0;
                 st_d = S_CLR;
               end else k_d = k_q + 1'b1;
      S_SLIDE: st_d = S_CLR;
      S_CLR:   st_d = S_CAL;
      S_CAL:   st_d = S_MINUS;
      S_MINUS: if (k_q == KB'(K_W-1)) begin
                 k_d  = '0;
                 st_d = S_RES;
               end else begin
                 k_d  = k_q + 1'b1;
                 st_d = S_CAL;
               end
      S_RES:   if (res_ready) begin
                 pos_inc = 1'b1;
                 st_d    = last ? S_DONE : (col_last ? S_PRIME : S_SLIDE);
               end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    // abort dominates everything, including a coincident start
    if (abort) begin
      st_d    = S_IDLE;
      k_d     = '0;
      pos_inc = 1'b0;
      pos_clr = 1'b1;
    end
  end

  // Outputs decoded from the next state so every strobe leaves a flop.
  always_comb begin
    so_d        = '0;
    so_d.pe_neg = PH_CAL;
    so_d.busy   = (st_d != S_IDLE) && (st_d != S_DONE);
    rd_row_d    = '0;
    rd_col_d    = '0;
    res_row_d   = '0;
    res_col_d   = '0;
    case (st_d)
      S_PRIME: begin
        so_d.rd_en = 1'b1;
        rd_row_d   = r_d;
        rd_col_d   = c_d + RW'(k_d);
      end
      S_SLIDE: begin
        so_d.rd_en = 1'b1;
        rd_row_d   = r_d;
        rd_col_d   = c_d + RW'(K_W-1);
      end
      S_CLR:   so_d.pe_clr = 1'b1;
      S_CAL: begin
        so_d.pe_ready = 1'b1;
        so_d.pe_neg   = PH_CAL;
        so_d.w_shift  = 1'b1;
      end
      S_MINUS: begin
        so_d.pe_ready = 1'b1;
        so_d.pe_neg   = PH_MINUS;
        so_d.img_rot  = 1'b1;
      end
      S_RES: begin
        so_d.res_valid = 1'b1;
        res_row_d      = r_d;
        res_col_d      = c_d;
      end
      S_DONE:  so_d.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      so_q     <= '0;
      col_load <= 1'b0;
      rd_row   <= '0;
      rd_col   <= '0;
      res_row  <= '0;
      res_col  <= '0;
    end else begin
      so_q     <= so_d;
      col_load <= so_q.rd_en & ~abort;
      rd_row   <= rd_row_d;
      rd_col   <= rd_col_d;
      res_row  <= res_row_d;
      res_col  <= res_col_d;
    end
  end

  assign rd_en     = so_q.rd_en;
  assign img_rot   = so_q.img_rot;
  assign w_shift   = so_q.w_shift;
  assign pe_clr    = so_q.pe_clr;
  assign pe_ready  = so_q.pe_ready;
  assign pe_neg    = so_q.pe_neg;
  assign res_valid = so_q.res_valid;
  assign busy      = so_q.busy;
  assign done      = so_q.done;

endmodule

// File: tb/tb_conv_win_seq.sv
// Directed bench for conv_win_seq: prologue timing, full scan, stall, abort, reset.
module tb_conv_win_seq;
  localparam int RW = 5;

  logic clk = 1'b0, rst_ni = 1'b1, start = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic rd_en, col_load, img_rot, w_shift, pe_clr, pe_ready, pe_neg, res_valid, busy, done;
  logic [RW-1:0] rd_row, rd_col, res_row, res_col;
  int total = 0, bad = 0, cyc = 0;
  int nh, er, ec, nws, nir, ndone, dcyc, stall;

  always #5 clk = ~clk;

  conv_win_seq #(.K_H(3), .K_W(3), .IN_H(16), .IN_W(15), .RW(RW)) dut (
    .clk(clk), .rst_ni(rst_ni), .start(start), .abort(abort),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .col_load(col_load),
    .img_rot(img_rot), .w_shift(w_shift), .pe_clr(pe_clr), .pe_ready(pe_ready),
    .pe_neg(pe_neg), .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_col(res_col), .busy(busy), .done(done)
  );

  // {rd_en,col_load,img_rot,w_shift,pe_clr,pe_ready,pe_neg,res_valid,busy,done}
  wire [9:0]  strb = {rd_en, col_load, img_rot, w_shift, pe_clr, pe_ready, pe_neg, res_valid, busy, done};
  wire [29:0] outs = {strb, rd_row, rd_col, res_row, res_col};

  logic [9:0] pro_tbl [11] = '{
    10'b1000000010, 10'b1100000010, 10'b1100000010, 10'b0100100010,
    10'b0001010010, 10'b0010011010, 10'b0001010010, 10'b0010011010,
    10'b0001010010, 10'b0010011010, 10'b0000000110
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // start from IDLE and check cycles 1..11 against the hand table
  task automatic prologue(input string tag);
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      chk($sformatf("%s strb c%0d", tag, n), 32'(strb), 32'(pro_tbl[n-1]));
      if (n <= 3) begin
        chk($sformatf("%s rd_col c%0d", tag, n), 32'(rd_col), 32'(n-1));
        chk($sformatf("%s rd_row c%0d", tag, n), 32'(rd_row), 32'd0);
      end
      if (n == 11) chk($sformatf("%s first res", tag), 32'({res_row, res_col}), 32'd0);
      if (n < 11) tick();
    end
  endtask

  initial begin
    #2 rst_ni = 1'b0;
    #10;
    chk("reset outs", 32'(outs), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // full scan, res_ready high
    prologue("p1");
    nh = 0; er = 0; ec = 0; nws = 3; nir = 3; ndone = 0; dcyc = 0;
    while (cyc < 1700) begin
      if (res_valid && res_ready) begin
        chk("order", 32'({res_row, res_col}), 32'(er*32 + ec));
        nh++;
        ec++;
        if (ec == 13) begin ec = 0; er++; end
      end
      tick();
      if (w_shift) nws++;
      if (img_rot) nir++;
      if (done) begin
        ndone++;
        dcyc = cyc;
        chk("busy at done", 32'(busy), 32'd0);
      end
      if (cyc == 12)
        chk("slide fetch", 32'({rd_en, rd_row, rd_col}), 32'({1'b1, 5'd0, 5'd3}));
      if (cyc >= 120 && cyc <= 122)
        chk($sformatf("row1 prime c%0d", cyc), 32'({rd_en, rd_row, rd_col}),
            32'({1'b1, 5'd1, 5'(cyc-120)}));
    end
    chk("scan handshakes", 32'(nh), 32'd182);
    chk("scan done count", 32'(ndone), 32'd1);
    chk("scan done cycle", 32'(dcyc), 32'd1667);
    chk("w_shift count", 32'(nws), 32'd546);
    chk("img_rot count", 32'(nir), 32'd546);
    chk("idle after scan", 32'(strb), 32'd0);

    // stall 5 cycles at window (2,7)
    start = 1'b1; tick(); start = 1'b0;
    nh = 0; er = 0; ec = 0; ndone = 0; stall = 0;
    for (int n = 0; n < 2500 && ndone == 0; n++) begin
      if (done) ndone++;
      if (res_valid && {res_row, res_col} == {5'd2, 5'd7} && stall <= 5) begin
        if (stall > 0)
          chk("stall hold", 32'({strb, res_row, res_col}), 32'({10'b0000000110, 5'd2, 5'd7}));
        res_ready = (stall == 5);
        stall++;
      end
      if (res_valid && res_ready) begin
        chk("stall order", 32'({res_row, res_col}), 32'(er*32 + ec));
        nh++;
        ec++;
        if (ec == 13) begin ec = 0; er++; end
      end
      tick();
    end
    res_ready = 1'b1;
    chk("stall handshakes", 32'(nh), 32'd182);
    chk("stall done", 32'(ndone), 32'd1);
    chk("stall cycles", 32'(stall), 32'd6);
    tick();

    // abort during MINUS, restart 3 cycles later
    start = 1'b1; cyc = 0; tick(); start = 1'b0;
    while (cyc < 6) tick();
    chk("pre-abort minus", 32'(strb), 32'(10'b0010011010));
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort idle", 32'(outs), 32'd0);
    ndone = 0;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'd0);
    prologue("p2");
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);

    // start and abort together
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start+abort", 32'(outs), 32'd0);

    // async reset in CAL
    start = 1'b1; cyc = 0; tick(); start = 1'b0;
    while (cyc < 5) tick();
    chk("pre-reset cal", 32'(strb), 32'(10'b0001010010));
    rst_ni = 1'b0;
    #1;
    chk("async reset", 32'(outs), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // start while busy is ignored
    prologue("p3");
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("busy start clr", 32'(strb), 32'(10'b0100100010));
    while (cyc < 20) tick();
    chk("busy start pos", 32'({res_valid, res_row, res_col}), 32'({1'b1, 5'd0, 5'd1}));
    abort = 1'b1; tick(); abort = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
